timer_seq_ctrl: RTL

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

---
 rtl/timer_seq_pkg.sv | 15 +
 rtl/cnt4_slice.sv | 31 +++
 rtl/timer_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/timer_seq_pkg.sv
// Shared widths and FSM encoding for the cascaded-slice interval timer.
package timer_seq_pkg;

    localparam int CNT_W      = 8;
    localparam int SLICE_W    = 4;
    localparam int PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

endpackage

// File: rtl/cnt4_slice.sv
// 4-bit synchronous counter slice (163-style): sync clear > sync load > count,
// with ripple-carry output RCO = ENT & (Q == 15) for cascading.
module cnt4_slice
    import timer_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_L,
    input  logic               CLR_L,
    input  logic               LD_L,
    input  logic               ENP,
    input  logic               ENT,
    input  logic [SLICE_W-1:0] D,
    output logic [SLICE_W-1:0] Q,
    output logic               RCO
);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            Q <= '0;
        end else if (!CLR_L) begin
            Q <= '0;
        end else if (!LD_L) begin
            Q <= D;
        end else if (ENP && ENT) begin
            Q <= Q + 1'b1;
        end
    end

    assign RCO = ENT && (Q == '1);

endmodule

// File: rtl/timer_seq_ctrl.sv
// Interval timer sequencer over cascaded cnt4_slice counters: loads ~PRESET, counts to FF.
// Optional build macro TIMER_SEQ_PRESCALE_EN adds a divide-by-16 prescaler slice.
module timer_seq_ctrl
    import timer_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [CNT_W-1:0] PRESET,
    output logic [CNT_W-1:0] CNT,
    output logic             BUSY,
    output logic             DONE
);

    state_t             state;
    logic [CNT_W-1:0]   preset_n;
    logic [SLICE_W-1:0] q_lo;
    logic [SLICE_W-1:0] q_hi;
    logic               rco_lo;
    logic               rco_hi;
    logic               run;
    logic               stop_act;
    logic               clr_l;
    logic               ld_l;
    logic               tick;
    logic               tick_last;
    logic               cnt_en;
    logic               expire;

    assign preset_n = ~PRESET;
    assign run      = (state == ST_RUN);
    assign stop_act = STOP && (state != ST_IDLE);
    assign clr_l    = !stop_act;
    assign ld_l     = (state != ST_LOAD);

`ifdef TIMER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] q_pre;
    logic                  rco_pre;

    cnt4_slice u_pre (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .CLR_L   (clr_l && ld_l),
        .LD_L    (1'b1),
        .ENP     (1'b1),
        .ENT     (run),
        .D       ('0),
        .Q       (q_pre),
        .RCO     (rco_pre)
    );

    // Main counter steps on the prescaler carry; expiry waits for a full 16-clock period at FF.
    assign tick      = rco_pre;
    assign tick_last = (q_pre == '1);
`else
    assign tick      = 1'b1;
    assign tick_last = 1'b1;
`endif

    // Cascaded RCO of the high slice marks CNT == FF in RUN; it freezes the count (no wrap).
    assign cnt_en = tick && !rco_hi;
    assign expire = rco_hi && tick_last;

    cnt4_slice u_lo (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .CLR_L   (clr_l),
        .LD_L    (ld_l),
        .ENP     (cnt_en),
        .ENT     (run),
        .D       (preset_n[SLICE_W-1:0]),
        .Q       (q_lo),
        .RCO     (rco_lo)
    );

    cnt4_slice u_hi (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .CLR_L   (clr_l),
        .LD_L    (ld_l),
        .ENP     (cnt_en),
        .ENT     (rco_lo),
        .D       (preset_n[CNT_W-1:SLICE_W]),
        .Q       (q_hi),
        .RCO     (rco_hi)
    );

    assign CNT = {q_hi, q_lo};

    // Per-edge priority: STOP, then expiry, then START (ignored unless idle).
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START && !STOP) begin
                        state <= ST_LOAD;
                        BUSY  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (expire) begin
                        state <= ST_EXPIRE;
                        DONE  <= 1'b1;
                    end
                end
                ST_EXPIRE: begin
                    if (STOP || !MODE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
